// File: rtl/meas_pkg.sv
// meas_pkg: shared FSM states and result limits for the measurement divider scheduler
package meas_pkg;
  typedef enum logic [2:0] {IDLE, D_SUM, D_SUM_W, D_DUTY, D_DUTY_W, F_ISS, F_WAIT} state_e;
  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int DUTY_MAX = 100;
  localparam int FREQ_MAX = (1 << 28) - 1;
endpackage

// File: rtl/meas_req_slot.sv
// meas_req_slot: single-entry request holder; a fresh capture always replaces the payload
module meas_req_slot #(
  parameter int W = 32
) (
  input  logic         clk_100M,
  input  logic         rst,
  input  logic         cap,
  input  logic [W-1:0] cap_data,
  input  logic         consume,
  output logic         pend,
  output logic [W-1:0] data
);
  logic         pend_q, pend_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    pend_d = cap | (pend_q & ~consume);
    data_d = cap ? cap_data : data_q;
  end
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end
  assign pend = pend_q;
  assign data = data_q;
endmodule

// File: rtl/meas_div_sched.sv
// meas_div_sched: shares one sequential divider between reciprocal-frequency and duty requests.
// Optional MEAS_TIMEOUT_EN adds a wait-state watchdog driving the sticky div_err flag.
module meas_div_sched
  import meas_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int DIV_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic [DIV_W-1:0] period_cnt,
  input  logic             period_vld,
  input  logic [DIV_W-1:0] gate_pos,
  input  logic [DIV_W-1:0] gate_sum,
  input  logic             gate_vld,
  output logic             div_start,
  output logic [DIV_W-1:0] div_a,
  output logic [DIV_W-1:0] div_b,
  input  logic             div_done,
  input  logic [DIV_W-1:0] div_q,
  output logic [27:0]      freq_low,
  output logic [6:0]       duty,
  output logic             freq_upd,
  output logic             duty_upd,
  output logic             div_err
);
  logic               f_pend, f_cons, d_pend, d_cons, tmo_hit;
  logic [DIV_W-1:0]   f_data;
  logic [2*DIV_W-1:0] d_data;
  state_e             st_q, st_d;
  logic [DIV_W-1:0]   pos_q, pos_d, arg_q, arg_d, div_a_q, div_a_d, div_b_q, div_b_d;
  logic               div_start_q, div_start_d, freq_upd_q, freq_upd_d, duty_upd_q, duty_upd_d;
  logic [27:0]        freq_q, freq_d;
  logic [6:0]         duty_q, duty_d;
  meas_req_slot #(.W(DIV_W)) u_f_slot (
    .clk_100M(clk_100M), .rst(rst), .cap(period_vld), .cap_data(period_cnt),
    .consume(f_cons), .pend(f_pend), .data(f_data)
  );
  meas_req_slot #(.W(2*DIV_W)) u_d_slot (
    .clk_100M(clk_100M), .rst(rst), .cap(gate_vld), .cap_data({gate_pos, gate_sum}),
    .consume(d_cons), .pend(d_pend), .data(d_data)
  );
  // arg_q carries sum, then sum/100, for duty; the period for frequency
  always_comb begin
    st_d        = st_q;
    pos_d       = pos_q;
    arg_d       = arg_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_start_d = 1'b0;
    freq_d      = freq_q;
    duty_d      = duty_q;
    freq_upd_d  = 1'b0;
    duty_upd_d  = 1'b0;
    f_cons      = 1'b0;
    d_cons      = 1'b0;
    case (st_q)
      IDLE: begin
        if (d_pend) begin
          d_cons = 1'b1;
          if (d_data[DIV_W-1:0] < DIV_W'(DUTY_MAX)) begin
            duty_d     = '0;
            duty_upd_d = 1'b1;
          end else begin
            pos_d = d_data[2*DIV_W-1:DIV_W];
            arg_d = d_data[DIV_W-1:0];
            st_d  = D_SUM;
          end
        end else if (f_pend) begin
          f_cons = 1'b1;
          if (f_data == '0) begin
            freq_d     = '0;
            freq_upd_d = 1'b1;
          end else begin
            arg_d = f_data;
            st_d  = F_ISS;
          end
        end
      end
      D_SUM: begin
        div_start_d = 1'b1;
        div_a_d     = arg_q;
        div_b_d     = DIV_W'(DUTY_MAX);
        st_d        = D_SUM_W;
      end
      D_SUM_W: begin
        if (div_done) begin
          arg_d = div_q;
          st_d  = D_DUTY;
        end else if (tmo_hit) st_d = IDLE;
      end
      D_DUTY: begin
        div_start_d = 1'b1;
        div_a_d     = pos_q;
        div_b_d     = arg_q;
        st_d        = D_DUTY_W;
      end
      D_DUTY_W: begin
        if (div_done) begin
          duty_d     = (div_q > DIV_W'(DUTY_MAX)) ? 7'(DUTY_MAX) : div_q[6:0];
          duty_upd_d = 1'b1;
          st_d       = IDLE;
        end else if (tmo_hit) st_d = IDLE;
      end
      F_ISS: begin
        div_start_d = 1'b1;
        div_a_d     = DIV_W'(CLK_HZ);
        div_b_d     = arg_q;
        st_d        = F_WAIT;
      end
      F_WAIT: begin
        if (div_done) begin
          freq_d     = (div_q > DIV_W'(FREQ_MAX)) ? 28'(FREQ_MAX) : div_q[27:0];
          freq_upd_d = 1'b1;
          st_d       = IDLE;
        end else if (tmo_hit) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      st_q        <= IDLE;
      pos_q       <= '0;
      arg_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_start_q <= 1'b0;
      freq_q      <= '0;
      duty_q      <= '0;
      freq_upd_q  <= 1'b0;
      duty_upd_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      pos_q       <= pos_d;
      arg_q       <= arg_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_start_q <= div_start_d;
      freq_q      <= freq_d;
      duty_q      <= duty_d;
      freq_upd_q  <= freq_upd_d;
      duty_upd_q  <= duty_upd_d;
    end
  end
`ifdef MEAS_TIMEOUT_EN
  logic        in_wait, err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
  assign in_wait = (st_q == D_SUM_W) | (st_q == D_DUTY_W) | (st_q == F_WAIT);
  assign tmo_hit = in_wait & ~div_done & (tmo_q == 16'(TIMEOUT_CYC - 1));
  always_comb begin
    tmo_d = in_wait ? tmo_q + 16'd1 : 16'd0;
    err_d = err_q | tmo_hit;
  end
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign div_err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign div_err = 1'b0;
`endif
  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign freq_low  = freq_q;
  assign duty      = duty_q;
  assign freq_upd  = freq_upd_q;
  assign duty_upd  = duty_upd_q;
endmodule

// File: tb/tb_meas_div_sched.sv
// tb_meas_div_sched: scoreboard bench with an 8-cycle divider model; MEAS_TIMEOUT_EN adds watchdog checks
module tb_meas_div_sched;
  localparam int LAT = 8;
  localparam longint FMAX = (64'd1 << 28) - 1;
  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] period_cnt = '0, gate_pos = '0, gate_sum = '0, div_a, div_b, div_q;
  logic        period_vld = 1'b0, gate_vld = 1'b0, div_start, div_done;
  logic [27:0] freq_low;
  logic [6:0]  duty;
  logic        freq_upd, duty_upd, div_err;
  logic        hold_done = 1'b0;
  logic [31:0] m_a, m_b;
  logic [63:0] ops[$], fq[$], dq[$];
  logic [63:0] e_op, e_f, e_d;
  int          n_chk = 0, n_pass = 0;
  always #5 clk_100M = ~clk_100M;
  meas_div_sched dut (
    .clk_100M(clk_100M), .rst(rst),
    .period_cnt(period_cnt), .period_vld(period_vld),
    .gate_pos(gate_pos), .gate_sum(gate_sum), .gate_vld(gate_vld),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q),
    .freq_low(freq_low), .duty(duty), .freq_upd(freq_upd), .duty_upd(duty_upd),
    .div_err(div_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask
  initial begin
    div_done = 1'b0;
    div_q = '0;
    forever begin
      @(negedge clk_100M);
      if (div_start === 1'b1) begin
        m_a = div_a;
        m_b = div_b;
        check("div_b_nonzero", 64'(m_b != 0), 64'd1);
        if (ops.size() == 0) check("unexpected_div_start", {m_a, m_b}, 64'd0);
        else begin
          e_op = ops.pop_front();
          check("div_operands", {m_a, m_b}, e_op);
        end
        repeat (LAT - 1) @(negedge clk_100M);
        if (!hold_done) begin
          div_q = (m_b != 0) ? m_a / m_b : '0;
          div_done = 1'b1;
          @(negedge clk_100M);
          div_done = 1'b0;
        end
      end
    end
  end
  always @(negedge clk_100M) begin
    if (!rst && freq_upd) begin
      if (fq.size() == 0) check("unexpected_freq_upd", 64'(freq_low), 64'hdead);
      else begin
        e_f = fq.pop_front();
        check("freq_low", 64'(freq_low), e_f);
      end
    end
    if (!rst && duty_upd) begin
      if (dq.size() == 0) check("unexpected_duty_upd", 64'(duty), 64'hdead);
      else begin
        e_d = dq.pop_front();
        check("duty", 64'(duty), e_d);
      end
    end
  end
  task automatic exp_freq(input logic [31:0] p);
    longint q;
    if (p == 0) fq.push_back(64'd0);
    else begin
      q = 100_000_000 / longint'(p);
      ops.push_back({32'd100_000_000, p});
      fq.push_back(64'(q > FMAX ? FMAX : q));
    end
  endtask
  task automatic exp_duty(input logic [31:0] pos, input logic [31:0] sum);
    logic [31:0] s;
    longint q;
    if (sum < 100) dq.push_back(64'd0);
    else begin
      s = sum / 100;
      q = longint'(pos) / longint'(s);
      ops.push_back({sum, 32'd100});
      ops.push_back({pos, s});
      dq.push_back(64'(q > 100 ? 100 : q));
    end
  endtask
  task automatic send(input logic pv, input logic [31:0] p, input logic gv, input logic [31:0] pos, input logic [31:0] sum);
    @(negedge clk_100M);
    period_cnt = p;
    period_vld = pv;
    gate_pos = pos;
    gate_sum = sum;
    gate_vld = gv;
    @(negedge clk_100M);
    period_vld = 1'b0;
    gate_vld = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((ops.size() + fq.size() + dq.size()) != 0 && n < 400) begin
      @(negedge clk_100M);
      n++;
    end
    check(tag, 64'(ops.size() + fq.size() + dq.size()), 64'd0);
    repeat (4) @(negedge clk_100M);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_div_start"}, 64'(div_start), 64'd0);
    check({tag, "_div_a"}, 64'(div_a), 64'd0);
    check({tag, "_div_b"}, 64'(div_b), 64'd0);
    check({tag, "_freq_low"}, 64'(freq_low), 64'd0);
    check({tag, "_duty"}, 64'(duty), 64'd0);
    check({tag, "_freq_upd"}, 64'(freq_upd), 64'd0);
    check({tag, "_duty_upd"}, 64'(duty_upd), 64'd0);
    check({tag, "_div_err"}, 64'(div_err), 64'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk_100M);
    rst = 1'b0;
    check_all_zero("reset");
    exp_freq(100_000);
    send(1, 100_000, 0, 0, 0);
    drain("t1_drain");
    exp_duty(25_000_000, 100_000_000);
    send(0, 0, 1, 25_000_000, 100_000_000);
    drain("t2_drain");
    exp_duty(3_000, 40_000);
    exp_freq(7);
    send(1, 7, 1, 3_000, 40_000);
    drain("t3_order_drain");
    exp_duty(0, 50);
    exp_freq(0);
    send(1, 0, 1, 0, 50);
    drain("t4_zero_drain");
    exp_duty(300, 200);
    send(0, 0, 1, 300, 200);
    drain("duty_clamp_drain");
    exp_duty(100, 100);
    send(0, 0, 1, 100, 100);
    drain("sum_100_drain");
    exp_duty(5, 99);
    send(0, 0, 1, 5, 99);
    drain("sum_99_drain");
    exp_freq(100_000);
    exp_freq(40);
    send(1, 100_000, 0, 0, 0);
    foreach (ops[i]) if (i < 0) $display("unused");
    period_cnt = 10;
    period_vld = 1'b1;
    @(negedge clk_100M);
    period_cnt = 20;
    @(negedge clk_100M);
    period_cnt = 40;
    @(negedge clk_100M);
    period_vld = 1'b0;
    drain("t5_latest_drain");
    check("t5_freq_final", 64'(freq_low), 64'd2_500_000);
    hold_done = 1'b1;
    ops.push_back({32'd100_000_000, 32'd1_000});
    send(1, 1_000, 0, 0, 0);
    repeat (12) @(negedge clk_100M);
    check("midwait_ops_issued", 64'(ops.size()), 64'd0);
    rst = 1'b1;
    @(negedge clk_100M);
    @(negedge clk_100M);
    check_all_zero("rst_midwait");
    rst = 1'b0;
    hold_done = 1'b0;
    repeat (4) @(negedge clk_100M);
`ifdef MEAS_TIMEOUT_EN
    hold_done = 1'b1;
    ops.push_back({32'd100_000_000, 32'd1_000});
    send(1, 1_000, 0, 0, 0);
    repeat (80) @(negedge clk_100M);
    check("timeout_div_err", 64'(div_err), 64'd1);
    hold_done = 1'b0;
    exp_freq(500);
    send(1, 500, 0, 0, 0);
    drain("after_timeout_drain");
    check("div_err_sticky", 64'(div_err), 64'd1);
    hold_done = 1'b1;
    ops.push_back({32'd100_000_000, 32'd2_000});
    send(1, 2_000, 0, 0, 0);
    repeat (20) @(negedge clk_100M);
    rst = 1'b1;
    @(negedge clk_100M);
    @(negedge clk_100M);
    check_all_zero("rst_after_timeout");
    rst = 1'b0;
    hold_done = 1'b0;
`else
    hold_done = 1'b1;
    ops.push_back({32'd100_000_000, 32'd2_000});
    send(1, 2_000, 0, 0, 0);
    repeat (100) @(negedge clk_100M);
    check("no_timeout_div_err", 64'(div_err), 64'd0);
    rst = 1'b1;
    @(negedge clk_100M);
    rst = 1'b0;
    hold_done = 1'b0;
`endif
    repeat (4) @(negedge clk_100M);
    exp_freq(3);
    send(1, 3, 0, 0, 0);
    drain("post_reset_drain");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
